// File: rtl/mod_n_down_sequencer.sv
// mod_n_down_sequencer
// Loadable down-counting index generator. On start it emits L-1 down to 0 on a
// valid/ready stream, one index per accepted handshake, then pulses done.
// It is the read-back side of the up-counting address path: it replays
// weight/pixel buffer addresses in descending order while the consumer
// throttles it through idx_ready.
// Every output comes straight from a flop, so no input reaches an output
// combinationally.

module mod_n_down_sequencer #(
    parameter int N      = 900,
    parameter int N_BITS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_BITS-1:0] len,
    input  logic              abort,
    input  logic              idx_ready,
    output logic              idx_valid,
    output logic [N_BITS-1:0] idx,
    output logic              last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The length check uses one extra bit so that N = 2^N_BITS stays legal.
    localparam logic [N_BITS:0]   N_WIDE    = (N_BITS + 1)'(N);
    // First index of a full-length run (len = 0 encodes L = N).
    localparam logic [N_BITS-1:0] FULL_IDX  = N_BITS'(N - 1);
    localparam logic [N_BITS-1:0] IDX_ONE   = N_BITS'(1);
    localparam logic [N_BITS-1:0] IDX_ZERO  = '0;

    state_t            r_state;
    state_t            w_stateNext;

    logic [N_BITS-1:0] r_idx;
    logic              r_idxValid;
    logic              r_last;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [N_BITS-1:0] w_idxNext;
    logic              w_idxValidNext;
    logic              w_lastNext;
    logic              w_busyNext;
    logic              w_doneNext;
    logic              w_errNext;

    logic              w_lenTooBig;
    logic [N_BITS-1:0] w_firstIdx;
    logic              w_handshake;
    logic              w_lastAccepted;
    logic              w_startAccepted;

    // A length above N cannot be served; len = 0 stands for the full modulus.
    assign w_lenTooBig     = ({1'b0, len} > N_WIDE);
    assign w_firstIdx      = (len == IDX_ZERO) ? FULL_IDX : (len - IDX_ONE);
    assign w_handshake     = r_idxValid & idx_ready;
    assign w_lastAccepted  = w_handshake & (r_idx == IDX_ZERO);
    // abort in IDLE swallows a simultaneous start, including its error check.
    assign w_startAccepted = start & ~abort;

    // State and all registered outputs; rst low clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_idx      <= IDX_ZERO;
            r_idxValid <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_idx      <= w_idxNext;
            r_idxValid <= w_idxValidNext;
            r_last     <= w_lastNext;
            r_busy     <= w_busyNext;
            r_done     <= w_doneNext;
            r_err      <= w_errNext;
        end
    end

    // Next state: abort wins over everything, the last handshake ends the run.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_startAccepted && !w_lenTooBig) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    w_stateNext = IDLE;
                end else if (w_lastAccepted) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; holding is the default so that
    // backpressure keeps idx, idx_valid and last stable.
    always_comb begin
        w_idxNext      = r_idx;
        w_idxValidNext = r_idxValid;
        w_busyNext     = r_busy;
        w_doneNext     = 1'b0;
        w_errNext      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_startAccepted) begin
                    if (w_lenTooBig) begin
                        w_errNext = 1'b1;
                    end else begin
                        w_idxNext      = w_firstIdx;
                        w_idxValidNext = 1'b1;
                        w_busyNext     = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    w_idxNext      = IDX_ZERO;
                    w_idxValidNext = 1'b0;
                    w_busyNext     = 1'b0;
                end else if (w_lastAccepted) begin
                    w_idxNext      = IDX_ZERO;
                    w_idxValidNext = 1'b0;
                    w_busyNext     = 1'b0;
                    w_doneNext     = 1'b1;
                end else if (w_handshake) begin
                    w_idxNext = r_idx - IDX_ONE;
                end
            end
            DONE: begin
                w_idxNext      = IDX_ZERO;
                w_idxValidNext = 1'b0;
                w_busyNext     = 1'b0;
            end
            default: begin
                w_idxNext      = IDX_ZERO;
                w_idxValidNext = 1'b0;
                w_busyNext     = 1'b0;
            end
        endcase
        w_lastNext = w_idxValidNext & (w_idxNext == IDX_ZERO);
    end

    assign idx_valid = r_idxValid;
    assign idx       = r_idx;
    assign last      = r_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_mod_n_down_sequencer.sv
// tb_mod_n_down_sequencer
// Scoreboard bench: every accepted start pushes the full descending index list
// into a queue; an independent monitor pops one entry per observed handshake
// and also checks done timing and stability under backpressure.

module tb_mod_n_down_sequencer;

    localparam int N      = 900;
    localparam int N_BITS = 10;

    logic              clk;
    logic              rst;
    logic              start;
    logic [N_BITS-1:0] len;
    logic              abort;
    logic              idxReady;
    logic              idxValid;
    logic [N_BITS-1:0] idx;
    logic              last;
    logic              busy;
    logic              done;
    logic              err;

    int checkCount = 0;
    int passCount  = 0;

    int   expQ[$];
    logic pendingDone = 1'b0;
    logic holdFlag    = 1'b0;
    int   holdIdx     = 0;

    mod_n_down_sequencer #(.N(N), .N_BITS(N_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .idx_ready (idxReady),
        .idx_valid (idxValid),
        .idx       (idx),
        .last      (last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and keep the pass/total counters.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Record a check that failed outright (timeout, unexpected event).
    task automatic failNow(input string name, input int actual);
        checkCount++;
        $display("[TB] FAIL %s: got %0d, expected none", name, actual);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each handshake, checks done and holds.
    always @(negedge clk) begin
        if (rst) begin
            if (pendingDone) begin
                checkOutput("done_pulse", done, 1);
                checkOutput("busy_after_last", busy, 0);
                pendingDone = 1'b0;
            end else if (done) begin
                failNow("unexpected_done", done);
            end
            if (holdFlag) begin
                checkOutput("hold_valid", idxValid, 1);
                checkOutput("hold_idx", idx, holdIdx);
                holdFlag = 1'b0;
            end
            if (idxValid && !abort) begin
                if (idxReady) begin
                    if (expQ.size() == 0) begin
                        failNow("unexpected_valid_idx", idx);
                    end else begin
                        int e;
                        e = expQ.pop_front();
                        checkOutput("idx", idx, e);
                        checkOutput("last", last, (e == 0) ? 1 : 0);
                        if (e == 0) pendingDone = 1'b1;
                    end
                end else begin
                    holdFlag = 1'b1;
                    holdIdx  = idx;
                end
            end
        end
    end

    // One run: readyMode 0 = always ready, 1 = pattern then ready, 2 = random.
    task automatic applyStimulus(input int lenVal, input int readyMode, input logic [15:0] readyPat,
                                 input int patLen, input int abortIdx, input bit startDuringRun);
        int L;
        int accepted;
        int cycles;
        bit aborted;
        bit r;
        bit first;
        L = (lenVal == 0) ? N : lenVal;
        for (int i = L - 1; i >= 0; i--) expQ.push_back(i);
        start = 1'b1;
        len   = N_BITS'(lenVal);
        tick();
        start = 1'b0;
        len   = N_BITS'($urandom);
        accepted = 0;
        cycles   = 0;
        aborted  = 1'b0;
        first    = 1'b1;
        while (accepted < L && cycles < 8 * L + 64) begin
            case (readyMode)
                0:       r = 1'b1;
                1:       r = (cycles < patLen) ? readyPat[cycles] : 1'b1;
                default: r = ($urandom_range(0, 99) < 70);
            endcase
            if (abortIdx >= 0 && (L - 1 - accepted) == abortIdx && r) abort = 1'b1;
            if (startDuringRun && cycles == 1) begin
                start = 1'b1;
                len   = N_BITS'(3);
            end
            idxReady = r;
            if (first) begin
                @(negedge clk);
                checkOutput("first_valid_latency", idxValid, 1);
                checkOutput("busy_in_run", busy, 1);
                checkOutput("first_idx", idx, L - 1);
                first = 1'b0;
            end
            tick();
            start = 1'b0;
            cycles++;
            if (abort) begin
                abort    = 1'b0;
                idxReady = 1'b0;
                expQ.delete();
                aborted  = 1'b1;
                @(negedge clk);
                checkOutput("abort_valid", idxValid, 0);
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_idx", idx, 0);
                tick();
                @(negedge clk);
                checkOutput("no_valid_after_abort", idxValid, 0);
                tick();
                break;
            end
            if (r) accepted++;
        end
        idxReady = 1'b0;
        if (!aborted) begin
            if (accepted < L) failNow("run_timeout", accepted);
            tick();
            checkOutput("queue_drained", expQ.size(), 0);
        end
    endtask

    // Start with an oversize length: err pulses once and nothing else moves.
    task automatic errCase(input int lenVal);
        start = 1'b1;
        len   = N_BITS'(lenVal);
        tick();
        start = 1'b0;
        @(negedge clk);
        checkOutput("err_pulse", err, 1);
        checkOutput("err_busy", busy, 0);
        checkOutput("err_valid", idxValid, 0);
        tick();
        @(negedge clk);
        checkOutput("err_one_cycle", err, 0);
        tick();
    endtask

    // abort together with start in IDLE: start dropped, no err.
    task automatic abortIdle(input int lenVal);
        start = 1'b1;
        abort = 1'b1;
        len   = N_BITS'(lenVal);
        tick();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_idle_err", err, 0);
        checkOutput("abort_idle_valid", idxValid, 0);
        checkOutput("abort_idle_busy", busy, 0);
        tick();
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passCount, checkCount + 1);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by randomized runs.
    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        idxReady = 1'b0;
        len      = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", idxValid, 0);
        checkOutput("reset_idx", idx, 0);
        checkOutput("reset_last", last, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        $display("[TB] nominal run len=4");
        applyStimulus(4, 0, 16'h0, 0, -1, 1'b0);

        $display("[TB] backpressure run len=3");
        applyStimulus(3, 1, 16'b0000_0000_0010_1001, 6, -1, 1'b0);

        $display("[TB] full-length run len=0");
        applyStimulus(0, 0, 16'h0, 0, -1, 1'b0);

        $display("[TB] oversize lengths");
        errCase(901);
        errCase(1023);

        $display("[TB] abort at idx 6 with start during run");
        applyStimulus(10, 0, 16'h0, 0, 6, 1'b1);
        applyStimulus(5, 0, 16'h0, 0, -1, 1'b1);

        $display("[TB] abort in idle");
        abortIdle(5);
        abortIdle(1000);

        $display("[TB] back-to-back runs");
        applyStimulus(2, 0, 16'h0, 0, -1, 1'b0);
        applyStimulus(1, 0, 16'h0, 0, -1, 1'b0);

        $display("[TB] async reset mid-run");
        for (int i = 9; i >= 0; i--) expQ.push_back(i);
        start = 1'b1;
        len   = N_BITS'(10);
        tick();
        start    = 1'b0;
        idxReady = 1'b1;
        repeat (4) tick();
        idxReady = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_idx", idx, 5);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_valid", idxValid, 0);
        checkOutput("async_reset_idx", idx, 0);
        checkOutput("async_reset_last", last, 0);
        checkOutput("async_reset_busy", busy, 0);
        checkOutput("async_reset_done", done, 0);
        expQ.delete();
        pendingDone = 1'b0;
        holdFlag    = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        applyStimulus(2, 0, 16'h0, 0, -1, 1'b0);

        $display("[TB] randomized runs");
        for (int k = 0; k < 40; k++) begin
            int kind;
            int lenVal;
            int abortIdx;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                errCase($urandom_range(N + 1, 1023));
            end else if (kind == 1) begin
                abortIdle($urandom_range(1, 1023));
            end else begin
                lenVal   = $urandom_range(1, 24);
                abortIdx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lenVal - 1) : -1;
                applyStimulus(lenVal, 2, 16'h0, 0, abortIdx, 1'b0);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mod_n_down_sequencer.md
Name: mod_N_down_sequencer

Overview:
- Loadable down-counting index generator with a start/done handshake and a valid/ready output stream.
- Emits the indices L-1, L-2, ..., 0, one per accepted handshake, then pulses done.
- Serves as the draining/read-back side of the up-counting address path: it replays weight/pixel buffer addresses in descending order.
- The consumer applies backpressure through idx_ready.

Parameters:
- N, 900, maximum run length; the counter modulus.
- N_BITS, 10, width of the index and length fields; must satisfy 2^N_BITS >= N.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a new run; sampled only in IDLE.
- len  input  N_BITS  run length L, sampled with start; 0 encodes L = N.
- abort  input  1  synchronous cancel of the current run.
- idx_ready  input  1  consumer accepts idx this cycle.
- idx_valid  output  1  idx is valid.
- idx  output  N_BITS  current index, counting down.
- last  output  1  high while idx_valid and idx == 0.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the final index is accepted.
- err  output  1  one-cycle pulse when start is given with len > N.

Behaviour:
- Reset (rst low, async): state = IDLE; idx = 0; idx_valid = 0; last = 0; busy = 0; done = 0; err = 0.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, RUN, DONE.
- IDLE, start=1, len <= N (or len = 0):
  - Next cycle: state = RUN; idx = L-1; idx_valid = 1; busy = 1.
  - Latency is exactly one cycle from start to the first valid idx.
- IDLE, start=1, len > N:
  - err = 1 for one cycle; stay in IDLE; no other output changes.
- RUN, handshake = idx_valid & idx_ready:
  - Handshake with idx > 0: idx decrements by 1 next cycle; idx_valid stays 1.
  - Handshake with idx == 0: next cycle state = DONE; idx_valid = 0; busy = 0; idx holds 0.
  - No handshake (idx_ready = 0): idx, idx_valid and last hold. No drop, no skip.
- last = idx_valid & (idx == 0). It is registered together with idx, and is high for every cycle the final index is presented.
- DONE: done = 1 for exactly one cycle. Next cycle: IDLE.
- Throughput: one index per cycle when idx_ready is held high. A run of length L takes L+2 cycles from start to the end of the done pulse.
- Start handling outside IDLE:
  - Start in RUN or DONE is ignored. It is not queued, and len is not re-sampled.
  - Start in the IDLE cycle immediately after DONE is accepted, so back-to-back runs have one idle bubble.
- abort=1 in RUN or DONE:
  - Next cycle: IDLE; idx_valid = 0; busy = 0; idx = 0; no done pulse.
  - abort has priority over a same-cycle handshake.
  - abort in IDLE has no effect and has priority over start (start dropped, err not raised).
- Wrap-around: idx never wraps. Decrement happens only when idx > 0, so underflow past 0 is impossible.
- Width rules:
  - L = N (len = 0) requires N-1 to be representable in N_BITS.
  - The comparison len > N is done at N_BITS+1 width, so N = 2^N_BITS is legal.
- Reset mid-run: immediately returns to the reset values; the run is lost and done is not produced.

Test Plan:
- Nominal run: start with len=4, idx_ready held 1.
  - idx_valid goes high 1 cycle later.
  - idx sequence 3,2,1,0 on consecutive cycles; last only with idx=0.
  - done pulses on the cycle after idx=0 is accepted; busy low from that cycle.
- Backpressure: len=3; idx_ready toggles 1,0,0,1,0,1.
  - Exactly 2,1,0 are accepted, each held stable while idx_ready=0.
  - done exactly once; idx_valid never drops mid-run.
- Full-length and error cases:
  - len=0 with N=900 → first idx=899; 900 handshakes before done.
  - len=901 → err pulse; busy stays 0; no idx_valid.
- Abort and ignored start:
  - len=10; abort asserted together with the handshake of idx=6 → IDLE next cycle; no done; no further idx_valid.
  - start asserted during RUN has no effect on idx.
- Back-to-back runs: start with len=2; start again in the IDLE cycle after done with len=1.
  - Sequence 1,0, done, idle, then 0 with last=1, done.
- Async reset mid-run: rst low while idx=5 and idx_ready=0.
  - All outputs are 0 asynchronously, before the next clock edge.
  - After release, start with len=2 → normal sequence 1,0.
